// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit counter direction predictor with mispredict redirect/flush sequencer
// Optional perf counters (br_count, mis_count) are enabled by defining BP_PERF_CNT_EN.
module branch_predict_ctrl #(
    parameter int PC_W      = 32,
    parameter int IDX_W     = 6,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            f_valid,
    input  logic [PC_W-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_Branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic [PC_W-1:0] ex_fallthru,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
`ifdef BP_PERF_CNT_EN
    output logic [31:0]     br_count,
    output logic [31:0]     mis_count,
`endif
    output logic            flush,
    output logic            busy
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_fcnt;
    logic [1:0]        r_ctr [DEPTH];
    logic [PC_W-1:0]   r_redirect_pc;
    logic [IDX_W-1:0]  w_f_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [1:0]        w_ctr_cur;
    logic [1:0]        w_ctr_nxt;
    logic              w_resolve;
    logic              w_mis;
    logic              w_unused;

    assign w_f_idx      = f_pc[IDX_W+1:2];
    assign w_ex_idx     = ex_pc[IDX_W+1:2];
    assign w_ctr_cur    = r_ctr[w_ex_idx];
    assign w_ctr_nxt    = ex_taken ? ((w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1)
                                   : ((w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1);
    assign w_resolve    = ex_valid & ex_Branch & (r_state == IDLE);
    assign w_mis        = w_resolve & (ex_pred_taken != ex_taken);
    // Reading the registered table gives the pre-update value on a same-cycle train.
    assign f_pred_taken = f_valid & r_ctr[w_f_idx][1];
    assign redirect_pc  = r_redirect_pc;
    assign w_unused     = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    // Counter table: reset to weakly not-taken, saturating train on each resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ctr[i] <= 2'b01;
        end else if (w_resolve) begin
            r_ctr[w_ex_idx] <= w_ctr_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_next   = r_state;
        redirect = 1'b0;
        flush    = 1'b0;
        busy     = 1'b0;
        w_next   = (r_state == IDLE)  ? (w_mis ? REDIR : IDLE) :
                   (r_state == REDIR) ? FLUSH :
                   ((r_fcnt == 3'd0) ? IDLE : FLUSH);
        redirect = (r_state == REDIR);
        flush    = (r_state != IDLE);
        busy     = (r_state != IDLE);
    end

    // Flush down-counter: loaded while in REDIR so FLUSH lasts FLUSH_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fcnt <= 3'd0;
        else        r_fcnt <= (r_state == REDIR) ? 3'(FLUSH_CYC - 1) :
                              ((r_state == FLUSH) && (r_fcnt != 3'd0)) ? r_fcnt - 3'd1 : r_fcnt;
    end

    // Capture the corrected fetch address at mispredict detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_redirect_pc <= '0;
        else if (w_mis) r_redirect_pc <= ex_taken ? ex_target : ex_fallthru;
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mis_count;
    assign br_count  = r_br_count;
    assign mis_count = r_mis_count;
    // Resolve and mispredict event counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else begin
            r_br_count  <= r_br_count + 32'(w_resolve);
            r_mis_count <= r_mis_count + 32'(w_mis);
        end
    end
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed stimulus with a behavioural model and literal spot checks
`timescale 1ns/100ps
module tb_branch_predict_ctrl;
    localparam int FLUSH_CYC = 2;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        f_valid = 0;
    logic [31:0] f_pc = 0;
    logic        f_pred_taken;
    logic        ex_valid = 0;
    logic        ex_Branch = 0;
    logic [31:0] ex_pc = 0;
    logic        ex_pred_taken = 0;
    logic        ex_taken = 0;
    logic [31:0] ex_target = 0;
    logic [31:0] ex_fallthru = 0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          m_ctr [64];
    int          m_left = 0;
    bit          m_redir = 0;
    logic [31:0] m_rpc = 0;

    branch_predict_ctrl #(.PC_W(32), .IDX_W(6), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .ex_valid(ex_valid), .ex_Branch(ex_Branch), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_fallthru(ex_fallthru),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a mispredict opens a window of FLUSH_CYC+1 flush cycles, the first with redirect.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            m_left = 0; m_redir = 0; m_rpc = 0;
        end else if (m_left == 0 && ex_valid && ex_Branch) begin
            int k;
            k = (ex_pc >> 2) % 64;
            m_ctr[k] = ex_taken ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3) : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
            if (ex_pred_taken != ex_taken) begin
                m_redir = 1;
                m_left  = FLUSH_CYC + 1;
                m_rpc   = ex_taken ? ex_target : ex_fallthru;
            end
        end else if (m_left > 0) begin
            m_left--;
            m_redir = 0;
        end
    end

    always @(negedge clk) begin
        chk("pred", {31'd0, f_pred_taken}, {31'd0, f_valid && m_ctr[(f_pc >> 2) % 64] >= 2});
        chk("redirect", {31'd0, redirect}, {31'd0, m_redir});
        chk("flush", {31'd0, flush}, {31'd0, m_left > 0});
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic br_now(input logic [31:0] pc, input logic pred, input logic tkn,
                          input logic [31:0] tgt, input logic [31:0] fall);
        ex_valid = 1; ex_Branch = 1; ex_pc = pc; ex_pred_taken = pred; ex_taken = tkn;
        ex_target = tgt; ex_fallthru = fall;
        step();
        ex_valid = 0; ex_Branch = 0;
    endtask

    task automatic br(input logic [31:0] pc, input logic pred, input logic tkn);
        br_now(pc, pred, tkn, pc + 32'h40, pc + 32'd4);
        wait_idle();
    endtask

    initial begin
        int n;
        int redirs;
        #1 rst_n = 0;
        #11 rst_n = 1;
        step();
        f_valid = 1; f_pc = 32'h100;
        #1;
        chk("reset_pred", {31'd0, f_pred_taken}, 32'd0);
        chk("reset_outs", {29'd0, redirect, flush, busy}, 32'd0);
        br(32'h100, 0, 1);
        #1 chk("train1_pred", {31'd0, f_pred_taken}, 32'd1);
        br(32'h100, 1, 1);
        br(32'h100, 1, 1);
        br(32'h100, 1, 0);
        br(32'h100, 1, 0);
        br(32'h100, 0, 0);
        br(32'h100, 0, 0);
        #1 chk("sat_low_pred", {31'd0, f_pred_taken}, 32'd0);
        br(32'h100, 0, 1);
        #1 chk("no_wrap_pred", {31'd0, f_pred_taken}, 32'd0);
        br_now(32'h200, 0, 1, 32'h180, 32'h204);
        #1;
        chk("mis_taken_redirect", {31'd0, redirect}, 32'd1);
        chk("mis_taken_pc", redirect_pc, 32'h180);
        n = 0;
        while (flush && n < 20) begin
            n++;
            step();
        end
        chk("flush_len", n, 32'd3);
        chk("busy_after", {31'd0, busy}, 32'd0);
        br_now(32'h200, 1, 0, 32'h180, 32'h204);
        #1 chk("mis_nt_pc", redirect_pc, 32'h204);
        wait_idle();
        br_now(32'h200, 0, 1, 32'h280, 32'h204);
        step();
        chk("in_flush", {30'd0, redirect, flush}, 32'd1);
        br_now(32'h300, 1, 0, 32'h400, 32'h304);
        redirs = 0;
        for (int i = 0; i < 8; i++) begin
            if (redirect) redirs++;
            step();
        end
        chk("wrong_path_redirs", redirs, 32'd0);
        f_pc = 32'h300;
        #1 chk("wrong_path_ctr", {31'd0, f_pred_taken}, 32'd1);
        f_pc = 32'h14;
        ex_valid = 1; ex_Branch = 1; ex_pc = 32'h14; ex_pred_taken = 0; ex_taken = 1;
        #1 chk("collision_old", {31'd0, f_pred_taken}, 32'd0);
        step();
        ex_valid = 0; ex_Branch = 0;
        chk("collision_new", {31'd0, f_pred_taken}, 32'd1);
        wait_idle();
        br_now(32'h40, 0, 1, 32'h80, 32'h44);
        #1 chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
        rst_n = 0;
        #1;
        chk("async_rst_outs", {29'd0, redirect, flush, busy}, 32'd0);
        chk("async_rst_rpc", redirect_pc, 32'd0);
        step();
        rst_n = 1;
        step();
        #1 chk("post_rst_pred", {31'd0, f_pred_taken}, 32'd0);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Direction predictor and misprediction sequencer for the RISC-V core's branch path. It holds a table of 2-bit saturating counters and gives a combinational taken/not-taken prediction at fetch. At execute it compares the branch unit's resolved `taken` against the carried prediction, trains the table, and on a mismatch runs a redirect/flush sequence that steers fetch to the correct PC and squashes wrong-path instructions.

Parameters:
PC_W, 32, width of all PC/address ports
IDX_W, 6, table index width; table depth = 2**IDX_W counters, index = pc[IDX_W+1:2]
FLUSH_CYC, 2, cycles of `flush` following the redirect cycle; legal range 1..7

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
f_valid  input  1  fetch stage holds a valid PC
f_pc  input  PC_W  fetch PC
f_pred_taken  output  1  prediction for f_pc, combinational
ex_valid  input  1  execute stage holds a valid instruction
ex_Branch  input  1  instruction is a conditional branch
ex_pc  input  PC_W  PC of the execute instruction
ex_pred_taken  input  1  prediction made for it at fetch, piped down
ex_taken  input  1  resolved outcome from the branch unit
ex_target  input  PC_W  branch target (pc+imm)
ex_fallthru  input  PC_W  pc+4
redirect  output  1  one-cycle pulse: load redirect_pc into fetch PC
redirect_pc  output  PC_W  corrected fetch address, valid while redirect=1
flush  output  1  squash IF/ID/EX wrong-path contents
busy  output  1  controller not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - every counter = 2'b01 (weakly not-taken); state = IDLE.
  - redirect=0, redirect_pc=0, flush=0, busy=0.
  - Deasserting rst_n mid-sequence abandons the sequence; no pending redirect survives.
- Prediction: f_pred_taken = f_valid & ctr[f_pc[IDX_W+1:2]][1]. Zero latency. When f_valid=0, f_pred_taken=0.
- Resolve event = ex_valid & ex_Branch & (state==IDLE). Resolves in REDIR/FLUSH are wrong-path: they are ignored, with no training and no redirect.
- Training on a resolve event, at the clock edge:
  - If ex_taken and the counter is below 3, counter+1.
  - If !ex_taken and the counter is above 0, counter-1.
  - Counters saturate at 2'b11 and 2'b00.
- Read/write collision: if fetch reads the same index being trained in that cycle, the read returns the pre-update value.
- Mispredict = resolve event & (ex_pred_taken != ex_taken).
- FSM states: IDLE, REDIR, FLUSH.
  - IDLE -> REDIR on a mispredict in cycle T. redirect_pc is registered as ex_taken ? ex_target : ex_fallthru.
  - REDIR (cycle T+1): redirect=1, flush=1, busy=1. Always moves to FLUSH next.
  - FLUSH (cycles T+2 .. T+1+FLUSH_CYC): redirect=0, flush=1, busy=1. A down-counter is loaded with FLUSH_CYC-1 on entry. Leave for IDLE when it reaches 0.
  - IDLE: redirect=0, flush=0, busy=0. redirect_pc holds its last value.
- Latency: mispredict detected at T, redirect seen at T+1, first cycle with no flush is T+2+FLUSH_CYC.
- A correct prediction causes no state change and no outputs; only the table is trained.
- Back-to-back mispredicts: the second can only be accepted in IDLE, so it is handled after the current sequence completes. Anything the pipeline presents meanwhile is wrong-path and is dropped.
- Non-branch or invalid instructions (ex_Branch=0 or ex_valid=0): no effect.

Optional Feature:
- Macro BP_PERF_CNT_EN.
- When defined, adds output ports br_count[31:0] and mis_count[31:0].
  - br_count increments on every resolve event; mis_count increments on every mispredict.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- When undefined, neither the ports nor the counter logic exist. All other behaviour is identical.

Test Plan:
- Reset: after rst_n low then high, f_valid=1 with any f_pc gives f_pred_taken=0. redirect, flush and busy are all 0.
- Training/saturation: resolve pc=0x100 taken three times with ex_pred_taken equal to the current prediction.
  - After the first resolve, f_pc=0x100 gives f_pred_taken=1.
  - Four not-taken resolves then return it to 0; the counter never wraps.
- Mispredict taken: ex_pc=0x200, ex_pred_taken=0, ex_taken=1, ex_target=0x180.
  - Next cycle: redirect=1 with redirect_pc=0x180.
  - flush stays high exactly 3 cycles with FLUSH_CYC=2, then busy=0.
- Mispredict not-taken: ex_pred_taken=1, ex_taken=0, ex_fallthru=0x204 -> redirect_pc=0x204.
- Wrong-path drop: during FLUSH, present a branch at pc=0x300 that mispredicts. There is no second redirect, and the counter at index 0x300>>2 is unchanged.
- Collision and async reset:
  - Train index 5 while fetching f_pc=0x14 in the same cycle -> the old prediction is returned.
  - Asserting rst_n low in the REDIR state clears flush and redirect immediately, without waiting for clk.
